// File: rtl/pnr_pkg.sv
// -----------------------------------------------------------------------------
// pnr_pkg
// Shared definitions for the photon-number-resolving trigger sequencer:
//   - default ADC sample width and number of photon thresholds
//   - width of the photon count (enough to hold 0..NUM_TH)
//   - FSM state encoding
// -----------------------------------------------------------------------------
package pnr_pkg;

    localparam int ADC_W_DEF  = 14;
    localparam int NUM_TH_DEF = 8;
    localparam int CNT_W      = $clog2(NUM_TH_DEF + 1);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_DELAY   = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } pnr_state_t;

endpackage

// File: rtl/pnr_trig_sequencer_schmitt.sv
// -----------------------------------------------------------------------------
// pnr_schmitt
// Schmitt-style trigger detector on a registered ADC sample stream.
// An arm flag is set once the sample has moved far enough away from the
// threshold (threshold -/+ hysteresis); a fire is reported while armed and the
// sample reaches the threshold. Every fire clears the arm flag, whether or not
// the downstream sequencer accepts it.
//
// Ports
//   clk_i       processing clock
//   rst_i       asynchronous active-high reset
//   en          sample stream valid (low until the first post-reset sample)
//   sample      trigger-source sample, signed
//   threshold   trigger threshold, signed
//   hysteresis  hysteresis magnitude, unsigned
//   is_posedge  1: rising crossing, 0: falling crossing
//   fire        single-cycle fire indication (combinational from registered
//               sample and arm flag)
// -----------------------------------------------------------------------------
module pnr_schmitt #(
    parameter int ADC_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic [ADC_W-1:0] sample,
    input  logic [ADC_W-1:0] threshold,
    input  logic [ADC_W-1:0] hysteresis,
    input  logic             is_posedge,
    output logic             fire
);

    // Two extra bits so threshold -/+ hysteresis can never wrap.
    logic signed [ADC_W+1:0] smp_x;
    logic signed [ADC_W+1:0] th_x;
    logic signed [ADC_W+1:0] hy_x;
    logic signed [ADC_W+1:0] th_lo;
    logic signed [ADC_W+1:0] th_hi;
    logic                    arm_cond;
    logic                    fire_cond;
    logic                    armed_q;

    assign smp_x = {{2{sample[ADC_W-1]}}, sample};
    assign th_x  = {{2{threshold[ADC_W-1]}}, threshold};
    assign hy_x  = {2'b00, hysteresis};
    assign th_lo = th_x - hy_x;
    assign th_hi = th_x + hy_x;

    always_comb begin
        arm_cond  = 1'b0;
        fire_cond = 1'b0;
        if (is_posedge) begin
            arm_cond  = (smp_x < th_lo);
            fire_cond = (smp_x >= th_x);
        end else begin
            arm_cond  = (smp_x > th_hi);
            fire_cond = (smp_x <= th_x);
        end
    end

    assign fire = en && armed_q && fire_cond;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
        end else if (en) begin
            if (fire) begin
                armed_q <= 1'b0;
            end else if (arm_cond) begin
                armed_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pnr_trig_sequencer.sv
// -----------------------------------------------------------------------------
// pnr_trig_sequencer
// Detects a trigger crossing on one ADC channel and, a programmable delay later,
// classifies the other channel against a set of photon thresholds. After each
// result the block stays busy until the clearance time (counted from the fire)
// has elapsed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ARMED   | idle, waiting for a fire from the Schmitt detector
//   DELAY   | counting down pnr_delay before the PNR sample
//   SAMPLE  | PNR source registered and compared against thresholds
//   HOLDOFF | result issued / pending, waiting out the clearance time
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   adc_a_i, adc_b_i       signed ADC samples
//   trig_is_adc_a          1: trigger on A, PNR on B; 0: the reverse
//   trig_threshold         signed trigger threshold
//   trig_hysteresis        unsigned hysteresis
//   trig_is_posedge        crossing direction
//   trig_clearance         re-arm holdoff in cycles, counted from the fire
//   pnr_delay              cycles between the fire and the PNR sample
//   adc_photon_threshold   NUM_TH packed signed thresholds, k in slice k
//   trig_o                 one-cycle pulse on an accepted trigger
//   busy_o                 high whenever the FSM is not ARMED
//   pnr_valid_o            one-cycle result strobe
//   pnr_count_o            photon number, held between strobes
//   event_cnt_o            completed results, wraps modulo 2^32
// -----------------------------------------------------------------------------
module pnr_trig_sequencer
    import pnr_pkg::*;
#(
    parameter int ADC_W  = ADC_W_DEF,
    parameter int NUM_TH = NUM_TH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADC_W-1:0]        adc_a_i,
    input  logic [ADC_W-1:0]        adc_b_i,
    input  logic                    trig_is_adc_a,
    input  logic [ADC_W-1:0]        trig_threshold,
    input  logic [ADC_W-1:0]        trig_hysteresis,
    input  logic                    trig_is_posedge,
    input  logic [31:0]             trig_clearance,
    input  logic [31:0]             pnr_delay,
    input  logic [NUM_TH*ADC_W-1:0] adc_photon_threshold,
    output logic                    trig_o,
    output logic                    busy_o,
    output logic                    pnr_valid_o,
    output logic [CNT_W-1:0]        pnr_count_o,
    output logic [31:0]             event_cnt_o
);

    logic [ADC_W-1:0] adc_a_q;
    logic [ADC_W-1:0] adc_b_q;
    logic             in_vld_q;

    logic [ADC_W-1:0] trig_src;
    logic [ADC_W-1:0] pnr_src;
    logic             fire;

    pnr_state_t       state_q;
    logic [31:0]      dly_cnt_q;
    logic [31:0]      clr_cnt_q;
    logic             pnr_is_b_q;
    logic [CNT_W-1:0] th_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;

    // Input register stage; in_vld_q keeps the reset value of the sample
    // registers from being treated as a real sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adc_a_q  <= '0;
            adc_b_q  <= '0;
            in_vld_q <= 1'b0;
        end else begin
            adc_a_q  <= adc_a_i;
            adc_b_q  <= adc_b_i;
            in_vld_q <= 1'b1;
        end
    end

    // Trigger source follows the live select; the PNR source uses the select
    // captured at the fire so a mid-event change cannot swap channels.
    assign trig_src = trig_is_adc_a ? adc_a_q : adc_b_q;
    assign pnr_src  = pnr_is_b_q    ? adc_b_q : adc_a_q;

    pnr_schmitt #(
        .ADC_W (ADC_W)
    ) u_schmitt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en         (in_vld_q),
        .sample     (trig_src),
        .threshold  (trig_threshold),
        .hysteresis (trig_hysteresis),
        .is_posedge (trig_is_posedge),
        .fire       (fire)
    );

    // Thermometer-style count: thresholds need not be sorted.
    always_comb begin
        th_cnt = '0;
        for (int k = 0; k < NUM_TH; k++) begin
            if ($signed(pnr_src) >= $signed(adc_photon_threshold[k*ADC_W +: ADC_W])) begin
                th_cnt = th_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_ARMED;
            dly_cnt_q   <= '0;
            clr_cnt_q   <= '0;
            pnr_is_b_q  <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            trig_o      <= 1'b0;
            busy_o      <= 1'b0;
            pnr_valid_o <= 1'b0;
            pnr_count_o <= '0;
            event_cnt_o <= '0;
        end else begin
            trig_o      <= 1'b0;
            pnr_valid_o <= 1'b0;

            // Result goes out the cycle after SAMPLE.
            if (pend_q) begin
                pend_q      <= 1'b0;
                pnr_valid_o <= 1'b1;
                pnr_count_o <= cnt_q;
                event_cnt_o <= event_cnt_o + 32'd1;
            end

            // Clearance runs from the fire regardless of the sampling phase.
            if (state_q != ST_ARMED && clr_cnt_q != 32'd0) begin
                clr_cnt_q <= clr_cnt_q - 32'd1;
            end

            case (state_q)
                ST_ARMED: begin
                    if (fire) begin
                        trig_o     <= 1'b1;
                        busy_o     <= 1'b1;
                        dly_cnt_q  <= pnr_delay;
                        clr_cnt_q  <= trig_clearance;
                        pnr_is_b_q <= trig_is_adc_a;
                        state_q    <= (pnr_delay != 32'd0) ? ST_DELAY : ST_SAMPLE;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt_q <= 32'd1) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - 32'd1;
                    end
                end
                ST_SAMPLE: begin
                    cnt_q   <= th_cnt;
                    pend_q  <= 1'b1;
                    state_q <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    // Leave only once the result is out and clearance has run down.
                    if (!pend_q && clr_cnt_q <= 32'd1) begin
                        state_q <= ST_ARMED;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ARMED;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pnr_trig_sequencer.sv
module tb_pnr_trig_sequencer;

    localparam int ADC_W  = 14;
    localparam int NUM_TH = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int a_v = 0, b_v = 0, th_v = 0, hy_v = 100, dly_v = 0, clr_v = 0;
    bit sel_v = 1'b1, pos_v = 1'b1;
    int th_arr [NUM_TH];

    logic [ADC_W-1:0]        adc_a_i, adc_b_i, trig_threshold, trig_hysteresis;
    logic                    trig_is_adc_a, trig_is_posedge;
    logic [31:0]             trig_clearance, pnr_delay;
    logic [NUM_TH*ADC_W-1:0] adc_photon_threshold;
    logic                    trig_o, busy_o, pnr_valid_o;
    logic [3:0]              pnr_count_o;
    logic [31:0]             event_cnt_o;

    assign adc_a_i         = a_v[ADC_W-1:0];
    assign adc_b_i         = b_v[ADC_W-1:0];
    assign trig_threshold  = th_v[ADC_W-1:0];
    assign trig_hysteresis = hy_v[ADC_W-1:0];
    assign trig_is_adc_a   = sel_v;
    assign trig_is_posedge = pos_v;
    assign trig_clearance  = clr_v;
    assign pnr_delay       = dly_v;

    always_comb begin
        adc_photon_threshold = '0;
        for (int k = 0; k < NUM_TH; k++)
            adc_photon_threshold[k*ADC_W +: ADC_W] = th_arr[k][ADC_W-1:0];
    end

    pnr_trig_sequencer #(.ADC_W(ADC_W), .NUM_TH(NUM_TH)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .adc_a_i              (adc_a_i),
        .adc_b_i              (adc_b_i),
        .trig_is_adc_a        (trig_is_adc_a),
        .trig_threshold       (trig_threshold),
        .trig_hysteresis      (trig_hysteresis),
        .trig_is_posedge      (trig_is_posedge),
        .trig_clearance       (trig_clearance),
        .pnr_delay            (pnr_delay),
        .adc_photon_threshold (adc_photon_threshold),
        .trig_o               (trig_o),
        .busy_o               (busy_o),
        .pnr_valid_o          (pnr_valid_o),
        .pnr_count_o          (pnr_count_o),
        .event_cnt_o          (event_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: events scheduled by edge number.
    int     e = 0;
    bit     m_armed = 0, prev_vld = 0, cap_sel = 0;
    int     prev_a = 0, prev_b = 0;
    int     busy_until = -1, samp_e = -1, val_e = -1, pend_cnt = 0;
    bit     exp_trig = 0, exp_valid = 0, exp_busy = 0;
    int     exp_cnt = 0;
    longint exp_ev = 0;

    int obs_trig = 0, obs_valid = 0, last_trig_e = -1, last_valid_e = -1;
    int n_vec = 0, n_err = 0;

    task automatic chk(string nm, longint act, longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, expv);
        end
    endtask

    task automatic model_step();
        int  src, pnr, j;
        bit  arm_c, fire_c, fire;
        exp_trig  = 0;
        exp_valid = 0;
        if (rst_i) begin
            m_armed = 0; prev_vld = 0; busy_until = -1; samp_e = -1; val_e = -1;
            exp_ev = 0; exp_cnt = 0; exp_busy = 0;
            return;
        end
        fire = 0;
        if (prev_vld) begin
            src = sel_v ? prev_a : prev_b;
            if (pos_v) begin
                arm_c  = src < th_v - hy_v;
                fire_c = src >= th_v;
            end else begin
                arm_c  = src > th_v + hy_v;
                fire_c = src <= th_v;
            end
            fire = m_armed && fire_c;
            if (fire) m_armed = 0;
            else if (arm_c) m_armed = 1;
        end
        if (e == samp_e) begin
            pnr = cap_sel ? prev_b : prev_a;
            pend_cnt = 0;
            for (int k = 0; k < NUM_TH; k++) if (pnr >= th_arr[k]) pend_cnt++;
        end
        if (e == val_e) begin
            exp_valid = 1;
            exp_cnt   = pend_cnt;
            exp_ev    = (exp_ev + 1) % 64'h1_0000_0000;
        end
        if (fire && e > busy_until) begin
            exp_trig   = 1;
            cap_sel    = sel_v;
            samp_e     = e + 1 + dly_v;
            val_e      = e + 2 + dly_v;
            j          = (clr_v > dly_v + 3) ? clr_v : dly_v + 3;
            busy_until = e + j;
        end
        exp_busy = (e < busy_until);
        prev_a = a_v; prev_b = b_v; prev_vld = 1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        e++;
        model_step();
        @(negedge clk_i);
        chk("trig_o",      longint'(trig_o),      longint'(exp_trig));
        chk("pnr_valid_o", longint'(pnr_valid_o), longint'(exp_valid));
        chk("busy_o",      longint'(busy_o),      longint'(exp_busy));
        chk("pnr_count_o", longint'(pnr_count_o), longint'(exp_cnt));
        chk("event_cnt_o", longint'(event_cnt_o), exp_ev);
        if (trig_o)      begin obs_trig++;  last_trig_e  = e; end
        if (pnr_valid_o) begin obs_valid++; last_valid_e = e; end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    int cross_e, f, t0, v0;

    initial begin
        for (int k = 0; k < NUM_TH; k++) th_arr[k] = 1000 * (k + 1);
        a_v = -500; b_v = 3500; th_v = 0; hy_v = 100; dly_v = 100; clr_v = 200;
        sel_v = 1; pos_v = 1;
        ticks(3);
        chk("reset_busy",  longint'(busy_o), 0);
        chk("reset_count", longint'(pnr_count_o), 0);
        chk("reset_evcnt", longint'(event_cnt_o), 0);
        rst_i = 1'b0;
        ticks(5);

        // Ramp A through the threshold, B at 3500.
        cross_e = -1;
        for (int v = -450; v <= 500; v += 50) begin
            a_v = v;
            tick();
            if (v == 0) cross_e = e;
        end
        ticks(110);
        chk("ramp_trig_count", obs_trig, 1);
        chk("ramp_trig_lat",   last_trig_e - cross_e, 1);
        chk("ramp_valid_lat",  last_valid_e - cross_e, 103);
        chk("ramp_pnr_count",  longint'(pnr_count_o), 3);
        chk("ramp_evcnt",      longint'(event_cnt_o), 1);
        f = last_trig_e;

        // Re-armed re-crossing inside clearance, then after it.
        while (e < f + 145) begin a_v = -500; tick(); end
        a_v = 500;
        while (e < f + 180) tick();
        chk("holdoff_ignored", obs_trig, 1);
        while (e < f + 248) begin a_v = -500; tick(); end
        a_v = 500;
        ticks(10);
        chk("after_clear_trig", obs_trig, 2);
        chk("after_clear_at",   last_trig_e - f, 250);

        // Oscillation inside the hysteresis band never re-arms.
        for (int i = 0; i < 300; i++) begin a_v = (i % 2) ? 50 : -50; tick(); end
        chk("osc_no_trig",  obs_trig, 2);
        chk("osc_evcnt",    longint'(event_cnt_o), 2);

        // Zero delay, B at the negative and positive rails.
        dly_v = 0; clr_v = 0; b_v = -8192;
        a_v = -500; ticks(3);
        a_v = 500; tick(); cross_e = e; ticks(6);
        chk("d0_neg_lat",   last_valid_e - cross_e, 3);
        chk("d0_neg_count", longint'(pnr_count_o), 0);
        b_v = 8191;
        a_v = -500; ticks(5);
        a_v = 500; tick(); cross_e = e; ticks(6);
        chk("d0_pos_lat",   last_valid_e - cross_e, 3);
        chk("d0_pos_count", longint'(pnr_count_o), 8);

        // Negedge trigger on B, PNR from A.
        sel_v = 0; pos_v = 0; a_v = 5500; b_v = 500;
        ticks(5);
        t0 = obs_trig;
        for (int v = 400; v >= -500; v -= 100) begin
            b_v = v; tick();
            if (v == 0) cross_e = e;
        end
        ticks(5);
        chk("neg_trig",  obs_trig - t0, 1);
        chk("neg_lat",   last_valid_e - cross_e, 3);
        chk("neg_count", longint'(pnr_count_o), 5);

        // Reset during DELAY aborts the event.
        sel_v = 1; pos_v = 1; dly_v = 100; clr_v = 0; b_v = 0;
        a_v = -500; ticks(5);
        a_v = 500; ticks(20);
        t0 = obs_trig; v0 = obs_valid;
        rst_i = 1'b1; ticks(2); rst_i = 1'b0;
        ticks(200);
        chk("rst_no_valid", obs_valid - v0, 0);
        chk("rst_evcnt",    longint'(event_cnt_o), 0);
        chk("rst_no_trig",  obs_trig - t0, 0);
        chk("rst_idle",     longint'(busy_o), 0);
        a_v = -500; ticks(3);
        a_v = 500; ticks(5);
        chk("rst_rearm",    obs_trig - t0, 1);
        ticks(110);

        // Randomized phase.
        dly_v = 3; clr_v = 10; hy_v = 100; th_v = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(19) == 0) a_v = ($urandom_range(1) != 0) ? 8191 : -8192;
            else a_v = rnd(-1500, 1500);
            if ($urandom_range(19) == 0) b_v = ($urandom_range(1) != 0) ? 8191 : -8192;
            else b_v = rnd(-1500, 1500);
            if ($urandom_range(49) == 0) begin dly_v = rnd(0, 15); clr_v = rnd(0, 40); end
            if ($urandom_range(99) == 0) begin
                th_v = rnd(-500, 500); hy_v = rnd(0, 300);
                pos_v = ($urandom_range(1) != 0); sel_v = ($urandom_range(1) != 0);
            end
            if ($urandom_range(399) == 0) begin
                th_v = ($urandom_range(1) != 0) ? 8191 : -8192; hy_v = 16383;
            end
            if ($urandom_range(199) == 0)
                for (int k = 0; k < NUM_TH; k++) th_arr[k] = rnd(-2000, 2000);
            if ($urandom_range(1499) == 0) begin
                rst_i = 1'b1; ticks(2); rst_i = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pnr_trig_sequencer.md
PNR_TRIG_SEQUENCER -- requirements
Module: pnr_trig_sequencer

Interface
REQ-001 SHALL have parameter ADC_W, default 14, ADC sample width (signed two's complement).
REQ-002 SHALL have parameter NUM_TH, default 8, number of photon thresholds.
REQ-003 SHALL have port clk_i, input, 1, processing clock. The block uses this one clock only.
REQ-004 SHALL have port rst_i, input, 1, reset. Reset is asynchronous and active-high.
REQ-005 SHALL have port adc_a_i, input, ADC_W, ADC channel A sample, signed.
REQ-006 SHALL have port adc_b_i, input, ADC_W, ADC channel B sample, signed.
REQ-007 SHALL have port trig_is_adc_a, input, 1. When 1, the trigger source is A and the PNR source is B; when 0, the reverse.
REQ-008 SHALL have these ports: trig_threshold (input, ADC_W, signed), trig_hysteresis (input, ADC_W, unsigned), trig_is_posedge (input, 1).
REQ-009 SHALL have these ports: trig_clearance (input, 32) and pnr_delay (input, 32), both in clock cycles.
REQ-010 SHALL have port adc_photon_threshold, input, NUM_TH*ADC_W, packed signed thresholds; threshold k occupies slice k.
REQ-011 SHALL have port trig_o, output, 1, one-cycle pulse on an accepted trigger.
REQ-012 SHALL have port busy_o, output, 1, high whenever the FSM is not in ARMED.
REQ-013 SHALL have ports pnr_valid_o (output, 1, one-cycle result strobe) and pnr_count_o (output, 4, photon number 0..NUM_TH).
REQ-014 SHALL have port event_cnt_o, output, 32, count of completed PNR results; wraps modulo 2^32.

Function
REQ-015 SHALL keep a Schmitt arm flag, evaluated every cycle on the trigger source. In posedge mode: arm when sample < threshold-hysteresis; fire when armed and sample >= threshold. In negedge mode: arm when sample > threshold+hysteresis; fire when armed and sample <= threshold.
REQ-016 SHALL compute threshold±hysteresis at ADC_W+2 bits signed, with no saturation or wrap.
REQ-017 SHALL clear the arm flag on every fire, including a fire that is ignored.
REQ-018 SHALL run an FSM with states ARMED, DELAY, SAMPLE, HOLDOFF.
REQ-019 In ARMED, a fire SHALL assert trig_o in the next cycle, capture pnr_delay and trig_clearance, and load both counters.
REQ-020 From ARMED after a fire, the FSM SHALL go to DELAY if the captured pnr_delay is greater than 0, else directly to SAMPLE.
REQ-021 In DELAY, the FSM SHALL decrement the delay counter and enter SAMPLE when it reaches 1. The PNR sample is therefore taken exactly pnr_delay+1 cycles after the fire cycle.
REQ-022 In SAMPLE, the block SHALL register the PNR source. pnr_count_o SHALL equal the number of k for which sample >= threshold k, using signed compares.
REQ-023 pnr_valid_o SHALL pulse one cycle after SAMPLE, and event_cnt_o SHALL increment in that same cycle.
REQ-024 The clearance counter SHALL run from the fire cycle. The FSM SHALL return to ARMED only after the PNR result is issued and clearance cycles have elapsed. A clearance of 0 or 1 means immediate re-arm after the result.
REQ-025 Fires that occur while not in ARMED SHALL be ignored: no trig_o, no queueing.
REQ-026 Config inputs SHALL be sampled only at the fire. Mid-event changes SHALL NOT affect the event in progress, except the thresholds, which are read in SAMPLE.
REQ-027 pnr_count_o SHALL hold its value between strobes.
REQ-028 The latency from the fire condition on the ADC input to pnr_valid_o SHALL be pnr_delay+3 cycles. This includes one input register stage.

Reset
REQ-029 While rst_i is high, the block SHALL set: FSM to ARMED, arm flag to 0, counters to 0, trig_o/pnr_valid_o/busy_o to 0, pnr_count_o to 0, event_cnt_o to 0.
REQ-030 A reset asserted mid-event SHALL abort the event with no pnr_valid_o. After release, the block SHALL need a fresh arm before it can fire.

Structure
REQ-031 Package pnr_pkg SHALL hold the ADC_W and NUM_TH defaults, the FSM state enum, and the count width (clog2(NUM_TH+1)).
REQ-032 Sub-module pnr_schmitt SHALL implement the arm/fire logic of REQ-015..017 and output a one-cycle fire.

Verification
REQ-033 posedge, threshold=0, hysteresis=100, delay=100, clearance=200, thresholds 1000..8000 step 1000. Ramp A from -500 to +500 with B=3500 -> trig_o once, pnr_valid_o 103 cycles after the crossing, pnr_count_o=3.
REQ-034 Same settings, with A re-crossing 150 cycles after the first fire (re-armed) -> no trig_o. A crossing at 250 cycles -> accepted.
REQ-035 A oscillating between -50 and +50 after the first fire -> no second trigger (never re-armed).
REQ-036 delay=0, B=-8192 -> pnr_count_o=0 three cycles after the crossing. B=8191 -> pnr_count_o=8.
REQ-037 negedge with trig_is_adc_a=0: B falls through threshold, A is PNR -> trigger detected on B, count derived from A.
REQ-038 rst_i pulsed during DELAY -> no pnr_valid_o, event_cnt_o=0, block idle until re-armed.
